// File: rtl/tracker_pkg.sv
// Shared types and constants for the photoresistor tracker sequencer.
package tracker_pkg;

   localparam logic [1:0] MOT_STOP = 2'b00;
   localparam logic [1:0] MOT_CW   = 2'b01;
   localparam logic [1:0] MOT_CCW  = 2'b11;

   localparam logic [1:0] CH_V1 = 2'd0;
   localparam logic [1:0] CH_V2 = 2'd1;
   localparam logic [1:0] CH_H1 = 2'd2;
   localparam logic [1:0] CH_H2 = 2'd3;

   localparam logic [7:0] WDOG_LIMIT = 8'd255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_COMPARE,
      ST_MOVE,
      ST_SETTLE
   } state_t;

   // Manual code 10 is not a legal motor code and is treated as stop.
   function automatic logic [1:0] map_manual(input logic [1:0] code);
      return (code == 2'b10) ? MOT_STOP : code;
   endfunction

endpackage

// File: rtl/tracker_sequencer_dwell_timer.sv
// Loadable down-counter shared by the MOVE and SETTLE windows; done pulses on the last cycle.
module tracker_dwell_timer
   import tracker_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == W'(1));

endmodule

// File: rtl/tracker_sequencer.sv
// Automatic-mode scheduler for the two-axis tracker; shares one ADC across four channels.
// Optional ADC watchdog enabled with `define TRACKER_WATCHDOG_EN.
module tracker_sequencer
   import tracker_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int DEADBAND   = 5,
   parameter int MOVE_CYC   = 50000,
   parameter int SETTLE_CYC = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [1:0]        manual_theta,
   input  logic [1:0]        manual_phi,
   output logic              adc_req,
   output logic [1:0]        adc_ch,
   input  logic              adc_ack,
   input  logic [DATA_W-1:0] adc_data,
   output logic [1:0]        s_out_theta,
   output logic [1:0]        s_out_phi,
   output logic              aligned,
   output logic              busy,
   output logic              fault
);

   localparam int unsigned DWELL_MAX = (MOVE_CYC > SETTLE_CYC) ? MOVE_CYC : SETTLE_CYC;
   localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);
   localparam logic [DATA_W:0] DB    = (DATA_W+1)'(DEADBAND);

   state_t              state;
   logic [DATA_W-1:0]   samp [4];
   logic                bal_v, bal_h;
   logic [1:0]          dir_v, dir_h;
   logic                dwell_load, dwell_done;
   logic [DWELL_W-1:0]  dwell_val;
   logic                wd_trip;

   // Magnitude of the difference on one extra bit so the extremes cannot wrap.
   function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      logic [DATA_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[DATA_W] ? (~d + (DATA_W+1)'(1)) : d;
   endfunction

   always_comb begin
      bal_v = (abs_diff(samp[CH_V1], samp[CH_V2]) <= DB);
      bal_h = (abs_diff(samp[CH_H1], samp[CH_H2]) <= DB);
      dir_v = (samp[CH_V1] > samp[CH_V2]) ? MOT_CW : MOT_CCW;
      dir_h = (samp[CH_H1] > samp[CH_H2]) ? MOT_CW : MOT_CCW;
   end

   always_comb begin
      dwell_load = 1'b0;
      dwell_val  = '0;
      if (!mode) begin
         if (state == ST_COMPARE) begin
            dwell_load = 1'b1;
            dwell_val  = (bal_v && bal_h) ? DWELL_W'(SETTLE_CYC) : DWELL_W'(MOVE_CYC);
         end else if (state == ST_MOVE && dwell_done) begin
            dwell_load = 1'b1;
            dwell_val  = DWELL_W'(SETTLE_CYC);
         end
      end
   end

   tracker_dwell_timer #(.W(DWELL_W)) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dwell_load),
      .load_val (dwell_val),
      .done     (dwell_done)
   );

`ifdef TRACKER_WATCHDOG_EN
   logic [7:0] wd_cnt;

   assign wd_trip = adc_req && !adc_ack && (wd_cnt == WDOG_LIMIT - 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         fault  <= 1'b0;
      end else begin
         wd_cnt <= (!adc_req || adc_ack) ? 8'd0 : wd_cnt + 8'd1;
         if (wd_trip) fault <= 1'b1;
      end
   end
`else
   assign wd_trip = 1'b0;
   assign fault   = 1'b0;
`endif

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         adc_req     <= 1'b0;
         adc_ch      <= CH_V1;
         s_out_theta <= MOT_STOP;
         s_out_phi   <= MOT_STOP;
         aligned     <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) samp[i] <= '0;
      end else begin
         // Motor outputs default to manual passthrough or stop; MOVE overrides below.
         if (mode) begin
            s_out_theta <= map_manual(manual_theta);
            s_out_phi   <= map_manual(manual_phi);
            aligned     <= 1'b0;
         end else begin
            s_out_theta <= MOT_STOP;
            s_out_phi   <= MOT_STOP;
         end

         case (state)
            ST_IDLE: begin
               if (!mode && !fault) begin
                  state   <= ST_SAMPLE;
                  adc_req <= 1'b1;
                  adc_ch  <= CH_V1;
               end
            end
            ST_SAMPLE: begin
               if (adc_req) begin
                  if (adc_ack) begin
                     samp[adc_ch] <= adc_data;
                     adc_req      <= 1'b0;
                     adc_ch       <= adc_ch + 2'd1;
                     if (mode) begin
                        state  <= ST_IDLE;
                        adc_ch <= CH_V1;
                     end else if (adc_ch == CH_H2) begin
                        state <= ST_COMPARE;
                     end
                  end
               end else if (mode) begin
                  state  <= ST_IDLE;
                  adc_ch <= CH_V1;
               end else begin
                  adc_req <= 1'b1;
               end
            end
            ST_COMPARE: begin
               if (mode) begin
                  state <= ST_IDLE;
               end else if (bal_v && bal_h) begin
                  state   <= ST_SETTLE;
                  aligned <= 1'b1;
               end else begin
                  state   <= ST_MOVE;
                  aligned <= 1'b0;
                  if (!bal_v) s_out_theta <= dir_v;
                  else        s_out_phi   <= dir_h;
               end
            end
            ST_MOVE: begin
               if (mode) begin
                  state <= ST_IDLE;
               end else if (dwell_done) begin
                  state <= ST_SETTLE;
               end else begin
                  s_out_theta <= s_out_theta;
                  s_out_phi   <= s_out_phi;
               end
            end
            ST_SETTLE: begin
               if (mode) begin
                  state <= ST_IDLE;
               end else if (dwell_done) begin
                  state   <= ST_SAMPLE;
                  adc_req <= 1'b1;
                  adc_ch  <= CH_V1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (wd_trip) begin
            state   <= ST_IDLE;
            adc_req <= 1'b0;
            adc_ch  <= CH_V1;
         end
      end
   end

endmodule

// File: doc/tracker_sequencer.md
# tracker_sequencer

Automatic-mode scheduler for the two-axis photoresistor tracker. It shares one ADC among the four photoresistor channels through a req/ack handshake and compares each vertical and horizontal pair against a deadband. It then drives one axis motor at a time for a fixed move window, followed by a settle window. It sits between the ADC front end and the theta/phi motor drivers, and a manual-mode input overrides it.

## Interface
Parameters:
- DATA_W, 16, ADC sample width.
- DEADBAND, 5, max |R1−R2| counted as balanced.
- MOVE_CYC, 50000, clock cycles a motor is driven per step (≥1).
- SETTLE_CYC, 1000, idle cycles after each step before resampling (≥1).

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = automatic, 1 = manual.
- manual_theta  in  2  manual theta command.
- manual_phi  in  2  manual phi command.
- adc_req  out  1  conversion request.
- adc_ch  out  2  channel: 0 R_vertical_1, 1 R_vertical_2, 2 R_horizontal_1, 3 R_horizontal_2.
- adc_ack  in  1  conversion done; adc_data valid this cycle.
- adc_data  in  DATA_W  conversion result.
- s_out_theta  out  2  theta motor code.
- s_out_phi  out  2  phi motor code.
- aligned  out  1  both pairs balanced at last compare.
- busy  out  1  FSM not in IDLE.
- fault  out  1  ADC watchdog fault (see Configuration).

## Operation
- Motor codes: 00 stop, 01 clockwise (R1>R2), 11 counter-clockwise (R1<R2). Code 10 is never driven. Manual input 10 maps to 00.
- FSM states:
  - IDLE → SAMPLE when mode=0.
  - SAMPLE: requests channels 0,1,2,3 in order. After the 4th ack → COMPARE.
  - COMPARE:
    - Vertical unbalanced → MOVE on theta.
    - Vertical balanced, horizontal unbalanced → MOVE on phi.
    - Both balanced → SETTLE with aligned=1.
  - MOVE → SETTLE after MOVE_CYC cycles.
  - SETTLE → SAMPLE after SETTLE_CYC cycles, or → IDLE if mode=1.
- Balance test: |R1−R2| computed on DATA_W+1 bits with no wrap. Balanced iff ≤ DEADBAND. Holds at R=0 and R=2^DATA_W−1.
- Only one axis is non-00 at any time in automatic mode.
- aligned clears on entering MOVE and in manual mode.
- Manual mode:
  - s_out_* follow the manual inputs, registered with 1 cycle latency.
  - From MOVE or SETTLE, the FSM goes to IDLE next cycle.
  - In SAMPLE with req outstanding, the FSM waits for ack and then goes to IDLE. A handshake is never abandoned.
- Returning to automatic: s_out_* = 00 on the next cycle, and sampling restarts at channel 0.

## Timing
- Reset values: adc_req 0, adc_ch 0, s_out_theta 00, s_out_phi 00, aligned 0, busy 0, fault 0. FSM in IDLE; counters 0.
- Handshake:
  - adc_req rises with adc_ch stable and holds until adc_ack is sampled high.
  - Data is captured on the ack edge; adc_req is 0 the following cycle.
  - The next request follows after a 1-cycle gap.
  - Ack while req=0 is ignored.
- Latency: 4th ack at cycle N → COMPARE at N+1 → s_out valid at N+2.
- Move window: the code is held exactly MOVE_CYC cycles, then 00 on SETTLE entry.
- Settle window: SETTLE_CYC cycles, then adc_req high on the next cycle.
- Reset mid-handshake: adc_req drops immediately (asynchronous), and the sequence restarts at channel 0.

## Configuration
- TRACKER_WATCHDOG_EN defined:
  - An 8-bit counter runs while adc_req=1.
  - 255 cycles without ack → drop req, set fault (sticky until rst_n), force s_out_* = 00, go to IDLE and stay there.
  - Manual mode still works while fault is set.
- TRACKER_WATCHDOG_EN undefined: the FSM waits for ack indefinitely, and fault is tied 0.

## Structure
- Package tracker_pkg holds:
  - motor codes MOT_STOP/MOT_CW/MOT_CCW;
  - the FSM state enum;
  - the channel index constants;
  - the watchdog limit.
- One sub-module, tracker_dwell_timer: a loadable down-counter with a done pulse. It is shared by MOVE and SETTLE, loaded with MOVE_CYC or SETTLE_CYC.

## Test plan
- Samples 1000,900,500,500 (ack 2 cycles after each req) → s_out_theta=01 for MOVE_CYC cycles, s_out_phi=00, then SETTLE.
- Samples 500,503,200,800 → theta balanced, s_out_phi=11, s_out_theta=00.
- Samples 0,5,65535,65530 → aligned=1, both outputs 00, no MOVE; checks boundaries with no wrap.
- mode=1 while req is outstanding on ch 2 → req holds until ack, FSM goes to IDLE. manual_theta=10 → s_out_theta=00; manual_phi=11 → 11 one cycle later.
- rst_n low during MOVE → all outputs reset immediately; after release, the first req is on ch 0.
- TRACKER_WATCHDOG_EN, ack never given → req drops after 255 cycles, fault=1 until reset.
